// File: rtl/jump_pc_unit_if.sv
// Bundle of the jump/PC stage signals between the datapath (master) and the
// program-counter stage (slave). Clock and reset travel as plain ports.
interface jump_pc_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] alu_out;
  logic             alu_or;
  logic             flag_we;
  logic [2:0]       jmp;
  logic             jmp_valid;
  logic [WIDTH-1:0] target;
  logic             stall;
  logic [WIDTH-1:0] pc;
  logic             zr;
  logic             ng;
  logic             taken;
  logic             halted;

  // Datapath side: presents the instruction's result and jump request.
  modport master (
    output alu_out, alu_or, flag_we, jmp, jmp_valid, target, stall,
    input  pc, zr, ng, taken, halted
  );

  // PC stage side: consumes the request, returns registered state.
  modport slave (
    input  alu_out, alu_or, flag_we, jmp, jmp_valid, target, stall,
    output pc, zr, ng, taken, halted
  );
endinterface

// File: rtl/jump_pc_unit.sv
// Hack-style program-counter stage: registers zr/ng flags from the ALU
// result, evaluates the 3-bit jump condition, selects the next PC and
// flags a halt when a taken jump targets its own address.
//
// Handshake: jmp_valid qualifies jmp for the current cycle only (there is no
// ready; the stage accepts every non-stalled cycle). stall=1 freezes pc, zr,
// ng and halted for that edge, suppresses flag capture and any jump, and
// forces taken low; the datapath must keep presenting the instruction until
// stall drops, at which point it completes on that edge.
module jump_pc_unit #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           reset,
  jump_pc_unit_if.slave bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             taken_q, taken_d;
  logic             halted_q, halted_d;

  logic zr_eff;
  logic ng_eff;
  logic cond;
  logic jump;

  // Jump decision uses freshly written flags in the same cycle (bypass).
  always_comb begin
    zr_eff = zr_q;
    ng_eff = ng_q;
    if (bus.flag_we) begin
      zr_eff = ~bus.alu_or;
      ng_eff = bus.alu_out[WIDTH-1];
    end
    cond = (bus.jmp[2] & ng_eff & ~zr_eff)
         | (bus.jmp[1] & zr_eff)
         | (bus.jmp[0] & ~ng_eff & ~zr_eff);
    jump = bus.jmp_valid & cond & ~bus.stall;
  end

  // Next-state selection: hold on stall, otherwise capture flags and
  // choose jump target or increment; halt is sticky until reset.
  always_comb begin
    pc_d     = pc_q;
    zr_d     = zr_q;
    ng_d     = ng_q;
    taken_d  = 1'b0;
    halted_d = halted_q;
    if (!bus.stall) begin
      if (bus.flag_we) begin
        zr_d = ~bus.alu_or;
        ng_d = bus.alu_out[WIDTH-1];
      end
      if (jump) begin
        pc_d    = bus.target;
        taken_d = 1'b1;
        if (bus.target == pc_q) begin
          halted_d = 1'b1;
        end
      end else begin
        pc_d = pc_q + WIDTH'(1);
      end
    end
  end

  // State registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      zr_q     <= 1'b0;
      ng_q     <= 1'b0;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      zr_q     <= zr_d;
      ng_q     <= ng_d;
      taken_q  <= taken_d;
      halted_q <= halted_d;
    end
  end

  assign bus.pc     = pc_q;
  assign bus.zr     = zr_q;
  assign bus.ng     = ng_q;
  assign bus.taken  = taken_q;
  assign bus.halted = halted_q;

endmodule
